// File: rtl/clint.sv
// Core-local interruptor: msip, mtime and mtimecmp behind a Wishbone classic slave.
// Drives the hart's machine timer and software interrupt lines from registered state.
module clint #(
    parameter int unsigned TICK_DIV   = 1,
    parameter int unsigned ADDR_WIDTH = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_addr_i,
    input  logic [31:0] wbs_dat_i,
    output logic [31:0] wbs_dat_o,
    output logic        wbs_ack_o,
    output logic        wbs_err_o,
    output logic        xint_mtip_o,
    output logic        xint_msip_o
);

    localparam logic [15:0] DIV_LAST = 16'(TICK_DIV - 1);

    localparam logic [ADDR_WIDTH-1:0] OFF_MSIP   = ADDR_WIDTH'(16'h0000);
    localparam logic [ADDR_WIDTH-1:0] OFF_CMP_LO = ADDR_WIDTH'(16'h4000);
    localparam logic [ADDR_WIDTH-1:0] OFF_CMP_HI = ADDR_WIDTH'(16'h4004);
    localparam logic [ADDR_WIDTH-1:0] OFF_MT_LO  = ADDR_WIDTH'(16'hBFF8);
    localparam logic [ADDR_WIDTH-1:0] OFF_MT_HI  = ADDR_WIDTH'(16'hBFFC);

    logic [15:0] presc;
    logic [63:0] mtime;
    logic [63:0] mtimecmp;
    logic        msip;

    logic [63:0] mtime_nxt;
    logic [31:0] rdata;
    logic        tick;
    logic        req;
    logic        wr;
    logic        mapped;
    logic        hit_msip;
    logic        hit_cmp_lo;
    logic        hit_cmp_hi;
    logic        hit_mt_lo;
    logic        hit_mt_hi;
    logic [ADDR_WIDTH-1:2] woff;
    logic        unused_addr;

    assign unused_addr = ^{wbs_addr_i[31:ADDR_WIDTH], wbs_addr_i[1:0]};

    function automatic logic [31:0] merge(
        input logic [31:0] old,
        input logic [31:0] dat,
        input logic [3:0]  sel
    );
        logic [31:0] res;
        res = old;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) res[b*8 +: 8] = dat[b*8 +: 8];
        end
        return res;
    endfunction

    assign woff       = wbs_addr_i[ADDR_WIDTH-1:2];
    assign hit_msip   = (woff == OFF_MSIP[ADDR_WIDTH-1:2]);
    assign hit_cmp_lo = (woff == OFF_CMP_LO[ADDR_WIDTH-1:2]);
    assign hit_cmp_hi = (woff == OFF_CMP_HI[ADDR_WIDTH-1:2]);
    assign hit_mt_lo  = (woff == OFF_MT_LO[ADDR_WIDTH-1:2]);
    assign hit_mt_hi  = (woff == OFF_MT_HI[ADDR_WIDTH-1:2]);
    assign mapped     = hit_msip | hit_cmp_lo | hit_cmp_hi
                      | hit_mt_lo | hit_mt_hi;

    assign req  = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o & ~wbs_err_o;
    assign wr   = req & wbs_we_i & mapped;
    assign tick = (presc == DIV_LAST);

    // A software write to either word suppresses the whole 64-bit tick.
    always_comb begin
        mtime_nxt = tick ? mtime + 64'd1 : mtime;
        if (wr & hit_mt_lo)
            mtime_nxt = {mtime[63:32], merge(mtime[31:0], wbs_dat_i, wbs_sel_i)};
        if (wr & hit_mt_hi)
            mtime_nxt = {merge(mtime[63:32], wbs_dat_i, wbs_sel_i), mtime[31:0]};
    end

    always_comb begin
        rdata = 32'd0;
        unique case (1'b1)
            hit_msip:   rdata = {31'd0, msip};
            hit_cmp_lo: rdata = mtimecmp[31:0];
            hit_cmp_hi: rdata = mtimecmp[63:32];
            hit_mt_lo:  rdata = mtime[31:0];
            hit_mt_hi:  rdata = mtime[63:32];
            default:    rdata = 32'd0;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            presc       <= '0;
            mtime       <= '0;
            mtimecmp    <= '1;
            msip        <= 1'b0;
            wbs_dat_o   <= '0;
            wbs_ack_o   <= 1'b0;
            wbs_err_o   <= 1'b0;
            xint_mtip_o <= 1'b0;
            xint_msip_o <= 1'b0;
        end else begin
            presc <= tick ? 16'd0 : presc + 16'd1;
            mtime <= mtime_nxt;
            if (wr & hit_cmp_lo)
                mtimecmp[31:0] <= merge(mtimecmp[31:0], wbs_dat_i, wbs_sel_i);
            if (wr & hit_cmp_hi)
                mtimecmp[63:32] <= merge(mtimecmp[63:32], wbs_dat_i, wbs_sel_i);
            if (wr & hit_msip & wbs_sel_i[0])
                msip <= wbs_dat_i[0];
            wbs_ack_o <= req & mapped;
            wbs_err_o <= req & ~mapped;
            if (req & ~wbs_we_i)
                wbs_dat_o <= rdata;
            xint_mtip_o <= (mtime >= mtimecmp);
            xint_msip_o <= msip;
        end
    end

endmodule
